// File: rtl/apb_timer_mch_if.sv
// APB bus bundle between a peripheral-bus master and the apb_timer_mch slave.
interface apb_timer_mch_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_timer_mch.sv
// Multi-channel APB up/down timer with shared prescaler, auto-reload and sticky flags.
// Optional macro TIMER_IRQ_EN: enables OVIE/UDIE storage and the irq outputs.
module apb_timer_mch #(
    parameter int CNT_W  = 8,
    parameter int NUM_CH = 2
) (
    input  logic              pclk,
    input  logic              presetn,
    apb_timer_mch_if.slave    apb,
    output logic [NUM_CH-1:0] irq
);
    localparam logic [4:0]       NUM_CH_L = 5'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
`ifdef TIMER_IRQ_EN
    localparam logic [7:0]       TCR_MASK = 8'hFF;
`else
    localparam logic [7:0]       TCR_MASK = 8'hF3;
`endif

    logic [3:0]       presc_q;
    logic [CNT_W-1:0] tdr_q [NUM_CH];
    logic [CNT_W-1:0] tdr_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    logic [7:0]       tcr_q [NUM_CH];
    logic [7:0]       tcr_d [NUM_CH];
    logic [1:0]       tsr_q [NUM_CH];
    logic [1:0]       tsr_d [NUM_CH];

    logic [3:0]  ch_sel;
    logic [1:0]  reg_sel;
    logic        addr_err;
    logic        wr_err;
    logic        acc_err;
    logic        wr_en;
    logic [31:0] rd_val;
    logic        unused_pwdata;

    assign ch_sel   = apb.paddr[7:4];
    assign reg_sel  = apb.paddr[3:2];
    assign addr_err = ({1'b0, ch_sel} >= NUM_CH_L) || (apb.paddr[1:0] != 2'b00);
    assign wr_err   = apb.pwrite && (reg_sel == 2'd3);
    assign acc_err  = addr_err || wr_err;
    assign wr_en    = apb.psel && apb.penable && apb.pwrite && !acc_err;
    assign unused_pwdata = ^apb.pwdata;

    // Prescaler tap for divide-by-2/4/8/16: low log2(N) bits all ones.
    function automatic logic tick_f(input logic [1:0] cks, input logic [3:0] p);
        case (cks)
            2'd0:    return p[0];
            2'd1:    return &p[1:0];
            2'd2:    return &p[2:0];
            default: return &p;
        endcase
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            tdr_d[c] = tdr_q[c];
            tcr_d[c] = tcr_q[c];
            tsr_d[c] = tsr_q[c];
            cnt_d[c] = cnt_q[c];
            if (wr_en && (ch_sel == 4'(c))) begin
                case (reg_sel)
                    2'd0:    tdr_d[c] = apb.pwdata[CNT_W-1:0];
                    2'd1:    tcr_d[c] = apb.pwdata[7:0] & TCR_MASK;
                    2'd2:    tsr_d[c] = tsr_q[c] & apb.pwdata[1:0];
                    default: ;
                endcase
            end
            // Counter uses the old TDR on reload and flag sets override a W0C clear.
            if (tcr_q[c][7]) begin
                cnt_d[c] = tdr_q[c];
            end else if (tcr_q[c][4] && tick_f(tcr_q[c][1:0], presc_q)) begin
                if (tcr_q[c][5]) begin
                    if (cnt_q[c] == '0) begin
                        cnt_d[c]    = tcr_q[c][6] ? tdr_q[c] : CNT_MAX;
                        tsr_d[c][1] = 1'b1;
                    end else begin
                        cnt_d[c] = cnt_q[c] - CNT_W'(1);
                    end
                end else begin
                    if (cnt_q[c] == CNT_MAX) begin
                        cnt_d[c]    = tcr_q[c][6] ? tdr_q[c] : '0;
                        tsr_d[c][0] = 1'b1;
                    end else begin
                        cnt_d[c] = cnt_q[c] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            presc_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                tdr_q[c] <= '0;
                tcr_q[c] <= '0;
                tsr_q[c] <= '0;
                cnt_q[c] <= '0;
            end
        end else begin
            presc_q <= presc_q + 4'd1;
            for (int c = 0; c < NUM_CH; c++) begin
                tdr_q[c] <= tdr_d[c];
                tcr_q[c] <= tcr_d[c];
                tsr_q[c] <= tsr_d[c];
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == 4'(c)) begin
                case (reg_sel)
                    2'd0:    rd_val = 32'(tdr_q[c]);
                    2'd1:    rd_val = 32'(tcr_q[c]);
                    2'd2:    rd_val = 32'(tsr_q[c]);
                    default: rd_val = 32'(cnt_q[c]);
                endcase
            end
        end
    end

    assign apb.prdata  = (apb.psel && !apb.pwrite && !acc_err) ? rd_val : '0;
    assign apb.pslverr = apb.psel && apb.penable && acc_err;
    assign apb.pready  = 1'b1;

`ifdef TIMER_IRQ_EN
    always_comb begin
        irq = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            irq[c] = (tsr_q[c][0] & tcr_q[c][3]) | (tsr_q[c][1] & tcr_q[c][2]);
        end
    end
`else
    assign irq = '0;
`endif
endmodule

// File: tb/tb_apb_timer_mch.sv
// Randomised bench for apb_timer_mch with a closed-form tick-count reference model.
module tb_apb_timer_mch;
    localparam int CNT_W  = 8;
    localparam int NUM_CH = 2;
    localparam int MAXV   = 1 << CNT_W;
`ifdef TIMER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic              pclk = 1'b0;
    logic              presetn = 1'b0;
    logic [NUM_CH-1:0] irq;
    int                total = 0;
    int                bad = 0;
    int                ecnt;

    always #5 pclk = ~pclk;

    apb_timer_mch_if bus ();

    apb_timer_mch #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .apb     (bus),
        .irq     (irq)
    );

    // Number of rising edges since reset release; also the prescaler phase.
    always @(posedge pclk or negedge presetn) begin
        if (!presetn) ecnt <= 0;
        else          ecnt <= ecnt + 1;
    end

    task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, output logic err, output int k);
        @(negedge pclk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = a; bus.pwdata = d;
        @(negedge pclk);
        bus.penable = 1'b1;
        #2 err = bus.pslverr;
        @(posedge pclk);
        #1 k = ecnt;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [7:0] a, output logic [31:0] d, output logic err, output int t);
        @(negedge pclk);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
        @(negedge pclk);
        bus.penable = 1'b1;
        #2 d = bus.prdata; err = bus.pslverr; t = ecnt;
        @(posedge pclk);
        #1 bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    // Advance to just after the edge where ecnt reaches 'target'.
    task automatic wait_edge(input int target);
        if (target > ecnt) begin
            repeat (target - ecnt) @(posedge pclk);
            #1;
        end
    endtask

    // Counter value and flag after edge t, for a channel loaded with tdr and enabled at edge w.
    function automatic void model(input int tdr, input bit dn, input bit are, input int n,
                                  input int w, input int t, output int cnt, output bit flag);
        int ticks;
        int len;
        ticks = (t / n) - (w / n);
        if (ticks < 0) ticks = 0;
        if (!dn) begin
            if (are) begin
                len = MAXV - tdr; cnt = tdr + (ticks % len); flag = (ticks >= len);
            end else begin
                cnt = (tdr + ticks) % MAXV; flag = ((tdr + ticks) >= MAXV);
            end
        end else begin
            if (are) begin
                len = tdr + 1; cnt = tdr - (ticks % len); flag = (ticks >= len);
            end else begin
                cnt = (((tdr - ticks) % MAXV) + MAXV) % MAXV; flag = (ticks > tdr);
            end
        end
    endfunction

    // Load TDR into the counter, clear flags, then enable with tcr; returns the enable edge.
    task automatic start_ch(input int c, input int tdr, input logic [7:0] tcr, output int w);
        logic e;
        int   k;
        apb_wr(8'(c * 16),     32'(tdr), e, k);
        apb_wr(8'(c * 16 + 4), 32'h80,   e, k);
        apb_wr(8'(c * 16 + 8), 32'h0,    e, k);
        apb_wr(8'(c * 16 + 4), 32'(tcr), e, w);
    endtask

    task automatic stop_ch(input int c);
        logic e;
        int   k;
        apb_wr(8'(c * 16 + 4), 32'h0, e, k);
        apb_wr(8'(c * 16 + 8), 32'h0, e, k);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic        e;
        int          t;
        total++;
        if (bus.pready !== 1'b1 || irq !== '0) begin
            bad++; $display("FAIL reset_out pready=%b irq=%b exp pready=1 irq=0", bus.pready, irq);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            for (int r = 0; r < 4; r++) begin
                apb_rd(8'(c * 16 + r * 4), d, e, t);
                total++;
                if (d !== 32'h0 || e !== 1'b0) begin
                    bad++; $display("FAIL reset_reg ch%0d off%0d got=%h err=%b exp=0 err=0", c, r * 4, d, e);
                end
            end
        end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        logic        e;
        int          t, w, k;
        start_ch(0, 0, 8'h12, w);
        wait_edge(w + 400);
        apb_rd(8'h08, d, e, t);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL ovf_early tsr=%h exp=0", d); end
        wait_edge(w + 2048 + 16 - 1);
        apb_rd(8'h08, d, e, t);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL ovf_set tsr=%h exp=1", d); end
        apb_wr(8'h08, 32'h0, e, k);
        apb_rd(8'h08, d, e, t);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL ovf_clear tsr=%h exp=0", d); end
        stop_ch(0);
    endtask

    task automatic test_underflow;
        logic [31:0] d;
        logic        e;
        int          t, w;
        start_ch(1, 5, 8'h31, w);
        wait_edge((w / 4 + 6) * 4 - 1);
        apb_rd(8'h1C, d, e, t);
        total++;
        if (d !== 32'hFF) begin bad++; $display("FAIL udf_cnt tcnt=%h exp=ff", d); end
        apb_rd(8'h18, d, e, t);
        total++;
        if (d !== 32'h2) begin bad++; $display("FAIL udf_flag tsr=%h exp=2", d); end
        apb_rd(8'h08, d, e, t);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL udf_ch0 tsr=%h exp=0", d); end
        stop_ch(1);
    endtask

    task automatic test_autoreload;
        logic [31:0] d;
        logic        e;
        int          t, w;
        start_ch(0, 8'hFE, 8'h50, w);
        for (int pass = 1; pass <= 2; pass++) begin
            wait_edge((w / 2 + 2 * pass) * 2 - 1);
            apb_rd(8'h0C, d, e, t);
            total++;
            if (d !== 32'hFE) begin bad++; $display("FAIL are_cnt pass%0d tcnt=%h exp=fe", pass, d); end
            apb_rd(8'h08, d, e, t);
            total++;
            if (d[0] !== 1'b1) begin bad++; $display("FAIL are_ovf pass%0d tsr=%h exp bit0=1", pass, d); end
        end
        stop_ch(0);
    endtask

    task automatic test_irq;
        logic [31:0] d;
        logic        e;
        int          t, w, k, wrap;
        start_ch(0, 8'hFC, 8'h18, w);
        wrap = (w / 2 + 4) * 2;
        while (ecnt < wrap + 2) begin
            @(posedge pclk); #1;
            total++;
            if (irq[0] !== (IRQ_ON && ecnt >= wrap)) begin
                bad++; $display("FAIL irq_wrap edge=%0d got=%b exp=%b", ecnt, irq[0], IRQ_ON && ecnt >= wrap);
            end
        end
        apb_rd(8'h04, d, e, t);
        total++;
        if (d !== (IRQ_ON ? 32'h18 : 32'h10)) begin
            bad++; $display("FAIL irq_tcr got=%h exp=%h", d, IRQ_ON ? 32'h18 : 32'h10);
        end
        apb_rd(8'h08, d, e, t);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL irq_flag tsr=%h exp=1", d); end
        apb_wr(8'h08, 32'h0, e, k);
        total++;
        if (irq[0] !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b exp=0", irq[0]); end
        stop_ch(0);
    endtask

    task automatic test_errors;
        logic [31:0] d;
        logic        e;
        int          t, k;
        apb_wr(8'h00, 32'h3C, e, k);
        total++;
        if (e !== 1'b0) begin bad++; $display("FAIL err_good_wr pslverr=%b exp=0", e); end
        apb_wr(8'h04, 32'h80, e, k);
        apb_wr(8'h04, 32'h00, e, k);
        apb_wr(8'h0C, 32'h77, e, k);
        total++;
        if (e !== 1'b1) begin bad++; $display("FAIL err_tcnt_wr pslverr=%b exp=1", e); end
        apb_rd(8'h0C, d, e, t);
        total++;
        if (d !== 32'h3C) begin bad++; $display("FAIL err_tcnt_kept tcnt=%h exp=3c", d); end
        apb_rd(8'h20, d, e, t);
        total++;
        if (e !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL err_bad_ch err=%b data=%h exp err=1 data=0", e, d); end
        apb_wr(8'h02, 32'hAA, e, k);
        total++;
        if (e !== 1'b1) begin bad++; $display("FAIL err_unaligned pslverr=%b exp=1", e); end
        apb_wr(8'h20, 32'h55, e, k);
        apb_rd(8'h00, d, e, t);
        total++;
        if (d !== 32'h3C) begin bad++; $display("FAIL err_tdr_kept tdr=%h exp=3c", d); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        logic        e;
        int          t, w;
        start_ch(0, 8'hF0, 8'h1C, w);
        wait_edge(w + 100);
        total++;
        if (irq[0] !== IRQ_ON) begin bad++; $display("FAIL rst_pre_irq got=%b exp=%b", irq[0], IRQ_ON); end
        @(negedge pclk); #2 presetn = 1'b0;
        #1;
        total++;
        if (irq !== '0) begin bad++; $display("FAIL rst_irq_now got=%b exp=0", irq); end
        repeat (2) @(posedge pclk);
        @(negedge pclk); presetn = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int r = 0; r < 4; r++) begin
                apb_rd(8'(c * 16 + r * 4), d, e, t);
                total++;
                if (d !== 32'h0) begin bad++; $display("FAIL rst_mid_reg ch%0d off%0d got=%h exp=0", c, r * 4, d); end
            end
        end
        total++;
        if (irq !== '0) begin bad++; $display("FAIL rst_mid_irq got=%b exp=0", irq); end
    endtask

    task automatic test_random;
        logic [31:0] d;
        logic        e;
        logic [7:0]  tcr;
        int          t, w, c, tdr, n, cnt;
        bit          dn, are, ovie, udie, flag, exp_irq;
        logic [1:0]  cks;
        for (int it = 0; it < 12; it++) begin
            c    = $urandom_range(0, NUM_CH - 1);
            tdr  = $urandom_range(0, MAXV - 1);
            dn   = 1'($urandom_range(0, 1));
            are  = 1'($urandom_range(0, 1));
            ovie = 1'($urandom_range(0, 1));
            udie = 1'($urandom_range(0, 1));
            cks  = 2'($urandom_range(0, 3));
            n    = 2 << cks;
            tcr  = {1'b0, are, dn, 1'b1, ovie, udie, cks};
            start_ch(c, tdr, tcr, w);
            wait_edge(w + $urandom_range(0, 600));
            apb_rd(8'(c * 16 + 12), d, e, t);
            model(tdr, dn, are, n, w, t, cnt, flag);
            total++;
            if (d !== 32'(cnt)) begin
                bad++; $display("FAIL rnd_cnt it%0d ch%0d tcr=%h tdr=%h got=%h exp=%h", it, c, tcr, tdr, d, cnt);
            end
            apb_rd(8'(c * 16 + 8), d, e, t);
            model(tdr, dn, are, n, w, t, cnt, flag);
            total++;
            if (d !== (flag ? (dn ? 32'h2 : 32'h1) : 32'h0)) begin
                bad++; $display("FAIL rnd_tsr it%0d ch%0d tcr=%h tdr=%h got=%h flag=%b", it, c, tcr, tdr, d, flag);
            end
            model(tdr, dn, are, n, w, ecnt, cnt, flag);
            exp_irq = IRQ_ON && flag && (dn ? udie : ovie);
            total++;
            if (irq[c] !== exp_irq) begin
                bad++; $display("FAIL rnd_irq it%0d ch%0d got=%b exp=%b", it, c, irq[c], exp_irq);
            end
            apb_rd(8'(c * 16 + 4), d, e, t);
            total++;
            if (d !== 32'(IRQ_ON ? tcr : (tcr & 8'hF3))) begin
                bad++; $display("FAIL rnd_tcr it%0d got=%h exp=%h", it, d, IRQ_ON ? tcr : (tcr & 8'hF3));
            end
            stop_ch(c);
        end
    endtask

    initial begin
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
        repeat (3) @(posedge pclk);
        @(negedge pclk); presetn = 1'b1;
        test_reset;
        test_overflow;
        test_underflow;
        test_autoreload;
        test_irq;
        test_errors;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/apb_timer_mch.md
# apb_timer_mch

Parametrised multi-channel APB timer; successor of the single 8-bit timer with the TDR/TCR/TSR register set. Provides `NUM_CH` independent up/down counters of `CNT_W` bits, each with a clock-divider select, an auto-reload option, sticky overflow/underflow flags and a per-channel interrupt. Sits on the peripheral APB bus next to the interrupt handler, which consumes `irq`.

## Interface
- `CNT_W`, 8: counter/TDR width, 2..32.
- `NUM_CH`, 2: number of channels, 1..8.
- `pclk`  in  1  bus and counter clock.
- `presetn`  in  1  asynchronous, active-low reset.
- `psel`  in  1  APB select.
- `penable`  in  1  APB access phase.
- `pwrite`  in  1  1 = write.
- `paddr`  in  8  byte address.
- `pwdata`  in  32  write data.
- `prdata`  out  32  read data, zero-extended.
- `pready`  out  1  tied to 1 (zero wait states).
- `pslverr`  out  1  error response.
- `irq`  out  NUM_CH  per-channel interrupt, level.

## Operation
- Channel `c` base address is `c*16`. Offsets: 0x0 TDR (RW, reload value), 0x4 TCR (RW), 0x8 TSR (W0C), 0xC TCNT (RO, live count).
- TCR bits:
  - [7] LOAD: TCNT <= TDR every cycle while set; counting is suppressed.
  - [6] ARE: auto-reload.
  - [5] DN: 1 = count down.
  - [4] EN.
  - [3] OVIE, [2] UDIE.
  - [1:0] CKS: divide by 2/4/8/16.
  - Bits above 7 read 0.
- TSR bits: [0] OVF, [1] UDF. Both are sticky. Writing 0 to a bit clears it; writing 1 has no effect.
- Prescaler:
  - One shared 4-bit free-running counter, running from reset.
  - Tick for divide-by-N is a 1-`pclk` pulse when `presc[log2(N)-1:0]` is all-ones.
- Count rules (on a tick, EN=1, LOAD=0):
  - Up: TCNT+1. At all-ones it wraps to 0, or to TDR if ARE=1, and sets OVF.
  - Down: TCNT-1. At 0 it wraps to all-ones, or to TDR if ARE=1, and sets UDF.
  - Arithmetic is modulo 2^CNT_W.
- `irq[c]` = (OVF & OVIE) | (UDF & UDIE), combinational from registered state.
- APB:
  - Write commits on `psel & penable & pwrite`.
  - `prdata` is valid in the access phase.
  - `pslverr`=1 for an address in a channel ≥ NUM_CH, an unaligned offset, or a write to TCNT. Such writes have no effect; such reads return 0.
- Simultaneous events:
  - LOAD beats count.
  - A flag set in the same cycle as a W0C clear of that flag: set wins.
  - A TDR write in the same cycle as a reload: the old TDR is reloaded.
  - A TCR write takes effect on the following cycle.
- Reset mid-operation: all state returns immediately to reset values, including the prescaler.

## Timing
- Reset values: TDR=0, TCR=0, TSR=0, TCNT=0, prescaler=0, `prdata`=0, `pslverr`=0, `irq`=0, `pready`=1.
- Register write is visible to reads and to the counter on the cycle after the access phase.
- From EN=1 with divide-by-N, the first increment occurs within N cycles; afterwards exactly every N cycles.
- A flag and `irq` assert on the same edge that TCNT wraps, so `irq` goes high 0 cycles after the wrap edge.
- A full count cycle from 0 (up, ARE=0) is 2^CNT_W ticks.

## Configuration
- `TIMER_IRQ_EN` defined:
  - `irq` is driven as above.
  - OVIE/UDIE are writable.
- `TIMER_IRQ_EN` undefined:
  - `irq` is tied to 0.
  - TCR[3:2] are not stored and read 0.
  - Flags still operate.

## Test plan
- Overflow timing, ch0, CNT_W=8: TDR=0, TCR=0x80 then 0x12 (up, div8).
  - 400 `pclk` later, TSR=0x00.
  - 2048+16 `pclk` later, TSR=0x01.
  - Writing TSR=0x00 then reading gives 0x00.
- Underflow: ch1, TDR=0x05, TCR=0x80 then 0x31 (down, div4).
  - After 6 ticks (~24 `pclk`): TSR=0x02, TCNT=0xFF.
  - ch0 TSR stays 0x00.
- Auto-reload: TDR=0xFE, TCR=0x80 then 0x50 (ARE, up, div2).
  - After 2 ticks: OVF=1, TCNT=0xFE.
  - After 2 more ticks: OVF still 1, TCNT=0xFE.
- Interrupt, with TIMER_IRQ_EN: TCR=0x18 and an overflow.
  - `irq[0]`=1 on the wrap edge.
  - Writing TSR=0x00 gives `irq[0]`=0 on the next cycle.
  - Without the macro, `irq` stays 0 and TCR reads 0x10.
- Errors:
  - Write to 0x0C gives `pslverr`=1 and TCNT unchanged.
  - Read at 0x20 with NUM_CH=2 gives `pslverr`=1 and `prdata`=0.
- Reset mid-count: assert `presetn`=0 while ch0 is counting.
  - All registers read 0 after release.
  - `irq`=0.
